// File: rtl/spike_event_logger.sv
// Spike detector for the membrane-voltage probe: hysteresis threshold crossing plus
// refractory hold-off, timestamped events buffered in a show-ahead FIFO drained by valid/ready.
module spike_event_logger #(
  parameter int V_WIDTH   = 25,
  parameter int T_WIDTH   = 64,
  parameter int DEPTH     = 16,
  parameter int RFR_WIDTH = 16
) (
  input  logic                       emu_clk,
  input  logic                       emu_rst,
  input  logic                       cke,
  input  logic                       enable,
  input  logic signed [V_WIDTH-1:0]  v_out,
  input  logic signed [V_WIDTH-1:0]  thr_hi,
  input  logic signed [V_WIDTH-1:0]  thr_lo,
  input  logic [RFR_WIDTH-1:0]       refract_cycles,
  input  logic [T_WIDTH-1:0]         emu_time,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [T_WIDTH-1:0]         evt_time,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic [31:0]                spike_count,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_BELOW   = 2'd0,
    ST_ABOVE   = 2'd1,
    ST_REFRACT = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [RFR_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  w_spike;

  logic [T_WIDTH-1:0]    r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]         w_rd_ptr_inc;
  logic [AW:0]           r_level;
  logic [T_WIDTH-1:0]    r_head, w_head_nxt;
  logic [31:0]           r_count;
  logic                  r_overflow;
  logic                  w_full, w_pop, w_push, w_drop;

  // Handshake: an event transfers on any cycle where evt_valid and evt_ready are both 1;
  // evt_valid never depends on evt_ready, and evt_time is stable while evt_valid is held.

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_state <= ST_BELOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_spike     = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_BELOW;
      w_cnt_nxt   = '0;
    end else if (cke) begin
      case (r_state)
        ST_BELOW: begin
          if (v_out >= thr_hi) begin
            w_state_nxt = ST_ABOVE;
            w_spike     = 1'b1;
          end
        end
        ST_ABOVE: begin
          if (v_out < thr_lo) begin
            if (refract_cycles == '0) begin
              w_state_nxt = ST_BELOW;
            end else begin
              w_state_nxt = ST_REFRACT;
              w_cnt_nxt   = refract_cycles;
            end
          end
        end
        ST_REFRACT: begin
          // A count of 0 here cannot occur normally; treat it like the last hold-off cycle.
          if (r_cnt <= RFR_WIDTH'(1)) begin
            w_state_nxt = ST_BELOW;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - RFR_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt = ST_BELOW;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_full       = (r_level == FULL_LVL);
  assign w_pop        = evt_valid & evt_ready;
  assign w_push       = w_spike & (~w_full | w_pop);
  assign w_drop       = w_spike & w_full & ~w_pop;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

  // Registered head keeps evt_time at its last value once the FIFO runs empty.
  always_comb begin
    w_head_nxt = r_head;
    if (w_pop) begin
      if (r_level == ONE_LVL) begin
        if (w_push) w_head_nxt = emu_time;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_inc];
      end
    end else if ((r_level == '0) && w_push) begin
      w_head_nxt = emu_time;
    end
  end

  always_ff @(posedge emu_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= emu_time;
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head <= w_head_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_ptr_inc;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE_LVL;
        2'b01:   r_level <= r_level - ONE_LVL;
        default: r_level <= r_level;
      endcase
      if (w_spike) r_count <= r_count + 32'd1;
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign evt_valid   = (r_level != '0);
  assign evt_time    = r_head;
  assign fifo_level  = r_level;
  assign spike_count = r_count;
  assign overflow    = r_overflow;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_spike_event_logger.sv
// Bench for spike_event_logger: directed scenarios plus randomized traffic checked
// against a queue-based reference model of spike detection and event buffering.
module tb_spike_event_logger;

  localparam int V_WIDTH   = 25;
  localparam int T_WIDTH   = 64;
  localparam int DEPTH     = 16;
  localparam int RFR_WIDTH = 16;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic                      emu_clk = 1'b0;
  logic                      emu_rst;
  logic                      cke, enable, evt_ready, clr_overflow;
  logic signed [V_WIDTH-1:0] v_out, thr_hi, thr_lo;
  logic [RFR_WIDTH-1:0]      refract_cycles;
  logic [T_WIDTH-1:0]        emu_time;
  logic                      evt_valid, overflow;
  logic [T_WIDTH-1:0]        evt_time;
  logic [LW-1:0]             fifo_level;
  logic [31:0]               spike_count;
  logic [1:0]                dbg_state;

  int n_vec, n_err;

  // Reference model: armed / fired / holding-off phases, queue of pending timestamps.
  logic [T_WIDTH-1:0] exp_q[$];
  logic [T_WIDTH-1:0] m_head;
  logic [31:0]        m_count;
  logic               m_ovf;
  int                 m_phase;
  int                 m_hold;

  always #5 emu_clk = ~emu_clk;

  spike_event_logger #(
    .V_WIDTH(V_WIDTH), .T_WIDTH(T_WIDTH), .DEPTH(DEPTH), .RFR_WIDTH(RFR_WIDTH)
  ) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .cke(cke), .enable(enable),
    .v_out(v_out), .thr_hi(thr_hi), .thr_lo(thr_lo), .refract_cycles(refract_cycles),
    .emu_time(emu_time), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_time(evt_time), .fifo_level(fifo_level), .spike_count(spike_count),
    .overflow(overflow), .clr_overflow(clr_overflow), .dbg_state(dbg_state)
  );

  task automatic model_clear();
    exp_q.delete();
    m_head  = '0;
    m_count = '0;
    m_ovf   = 1'b0;
    m_phase = 0;
    m_hold  = 0;
  endtask

  task automatic model_step();
    bit pop, spike, drop;
    pop   = (exp_q.size() != 0) && evt_ready;
    spike = 1'b0;
    drop  = 1'b0;
    if (!enable) begin
      m_phase = 0;
      m_hold  = 0;
    end else if (cke) begin
      if (m_phase == 0) begin
        if (v_out >= thr_hi) begin spike = 1'b1; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (v_out < thr_lo) begin
          m_hold  = int'(refract_cycles);
          m_phase = (m_hold == 0) ? 0 : 2;
        end
      end else begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_phase = 0;
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (spike) begin
      m_count = m_count + 32'd1;
      if (exp_q.size() < DEPTH) exp_q.push_back(emu_time);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    if (exp_q.size() != 0) m_head = exp_q[0];
  endtask

  task automatic tick();
    model_step();
    @(posedge emu_clk);
    #1;
    emu_time = emu_time + 1;
  endtask

  task automatic do_reset();
    emu_rst = 1'b1;
    @(posedge emu_clk); #1;
    @(posedge emu_clk); #1;
    emu_rst = 1'b0;
    model_clear();
  endtask

  // One spike with zero refractory: cross upward, then fall below thr_lo to re-arm.
  task automatic spike_once(output logic [T_WIDTH-1:0] t);
    t = emu_time;
    v_out = 150; tick();
    v_out = 0;   tick();
  endtask

  task automatic test_reset();
    logic [T_WIDTH-1:0] t;
    do_reset();
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", evt_valid); end
    n_vec++; if (evt_time !== '0) begin n_err++; $display("FAIL rst_time: got %0d exp 0", evt_time); end
    n_vec++; if (fifo_level !== '0) begin n_err++; $display("FAIL rst_level: got %0d exp 0", fifo_level); end
    n_vec++; if (spike_count !== '0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", spike_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b exp 0", overflow); end
    refract_cycles = 0; evt_ready = 0; emu_time = 500;
    for (int i = 0; i < 3; i++) spike_once(t);
    n_vec++; if (fifo_level !== LW'(3)) begin n_err++; $display("FAIL pre_rst_level: got %0d exp 3", fifo_level); end
    #3;
    emu_rst = 1'b1;
    #1;
    n_vec++; if (evt_valid !== 1'b0 || fifo_level !== '0 || evt_time !== '0 ||
                 spike_count !== '0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst: got valid=%b level=%0d time=%0d count=%0d ovf=%b exp all 0",
               evt_valid, fifo_level, evt_time, spike_count, overflow);
    end
    @(posedge emu_clk); #1;
    emu_rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single_spike();
    int ramp [6] = '{0, 30, 60, 90, 120, 150};
    do_reset();
    thr_hi = 100; thr_lo = 20; refract_cycles = 4; evt_ready = 0; emu_time = 996;
    for (int i = 0; i < 6; i++) begin
      v_out = V_WIDTH'(ramp[i]);
      tick();
      if (i == 3) begin
        n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL early_valid: got %b exp 0", evt_valid); end
      end
      if (i == 4) begin
        n_vec++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL spike_valid: got %b exp 1", evt_valid); end
        n_vec++; if (evt_time !== 64'd1000) begin n_err++; $display("FAIL spike_time: got %0d exp 1000", evt_time); end
      end
    end
    n_vec++; if (spike_count !== 32'd1) begin n_err++; $display("FAIL single_count: got %0d exp 1", spike_count); end
    n_vec++; if (fifo_level !== LW'(1)) begin n_err++; $display("FAIL single_level: got %0d exp 1", fifo_level); end
    evt_ready = 1; tick(); evt_ready = 0;
    n_vec++; if (evt_valid !== 1'b0 || fifo_level !== '0) begin
      n_err++; $display("FAIL drain_one: got valid=%b level=%0d exp 0/0", evt_valid, fifo_level);
    end
    n_vec++; if (evt_time !== 64'd1000) begin n_err++; $display("FAIL hold_time: got %0d exp 1000", evt_time); end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 10; i++) begin
      v_out = (i % 2 == 0) ? 25'sd90 : 25'sd110;
      tick();
    end
    n_vec++; if (spike_count !== 32'd1) begin n_err++; $display("FAIL hyst_count: got %0d exp 1", spike_count); end
    v_out = 10; tick();
    v_out = 150;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (spike_count !== 32'd1 || evt_valid !== 1'b0) begin
      n_err++; $display("FAIL refract_ignore: got count=%0d valid=%b exp 1/0", spike_count, evt_valid);
    end
    tick();
    n_vec++; if (spike_count !== 32'd2 || evt_valid !== 1'b1) begin
      n_err++; $display("FAIL refract_rearm: got count=%0d valid=%b exp 2/1", spike_count, evt_valid);
    end
    n_vec++; if (evt_time !== m_head) begin n_err++; $display("FAIL rearm_time: got %0d exp %0d", evt_time, m_head); end
  endtask

  task automatic test_overflow();
    logic [T_WIDTH-1:0] t_exp [18];
    do_reset();
    thr_hi = 100; thr_lo = 20; refract_cycles = 0; evt_ready = 0; emu_time = 64'h1_0000_0000;
    for (int i = 0; i < 18; i++) spike_once(t_exp[i]);
    n_vec++; if (fifo_level !== LW'(16)) begin n_err++; $display("FAIL ovf_level: got %0d exp 16", fifo_level); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    n_vec++; if (spike_count !== 32'd18) begin n_err++; $display("FAIL ovf_count: got %0d exp 18", spike_count); end
    evt_ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_vec++; if (evt_valid !== 1'b1 || evt_time !== t_exp[i]) begin
        n_err++; $display("FAIL drain_order[%0d]: got valid=%b time=%0d exp 1/%0d", i, evt_valid, evt_time, t_exp[i]);
      end
      tick();
    end
    evt_ready = 0;
    n_vec++; if (evt_valid !== 1'b0 || fifo_level !== '0) begin
      n_err++; $display("FAIL drain_empty: got valid=%b level=%0d exp 0/0", evt_valid, fifo_level);
    end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b exp 1", overflow); end
    clr_overflow = 1; tick(); clr_overflow = 0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [T_WIDTH-1:0] t_exp [16];
    do_reset();
    thr_hi = 100; thr_lo = 20; refract_cycles = 0; evt_ready = 0; emu_time = 2000;
    for (int i = 0; i < 16; i++) spike_once(t_exp[i]);
    n_vec++; if (fifo_level !== LW'(16) || overflow !== 1'b0) begin
      n_err++; $display("FAIL fill: got level=%0d ovf=%b exp 16/0", fifo_level, overflow);
    end
    v_out = 150; evt_ready = 1; tick();
    v_out = 0; evt_ready = 0;
    n_vec++; if (fifo_level !== LW'(16) || overflow !== 1'b0) begin
      n_err++; $display("FAIL full_push_pop: got level=%0d ovf=%b exp 16/0", fifo_level, overflow);
    end
    n_vec++; if (evt_time !== t_exp[1]) begin n_err++; $display("FAIL full_pp_head: got %0d exp %0d", evt_time, t_exp[1]); end
    n_vec++; if (spike_count !== 32'd17) begin n_err++; $display("FAIL full_pp_count: got %0d exp 17", spike_count); end
  endtask

  task automatic test_cke_enable();
    do_reset();
    thr_hi = 100; thr_lo = 20; refract_cycles = 8; evt_ready = 0;
    cke = 0; v_out = 150;
    for (int i = 0; i < 5; i++) tick();
    n_vec++; if (spike_count !== 32'd0 || evt_valid !== 1'b0) begin
      n_err++; $display("FAIL cke_gate: got count=%0d valid=%b exp 0/0", spike_count, evt_valid);
    end
    cke = 1; tick();
    n_vec++; if (spike_count !== 32'd1) begin n_err++; $display("FAIL cke_resume: got %0d exp 1", spike_count); end
    v_out = 0; tick();
    enable = 0; tick();
    enable = 1; v_out = 150; tick();
    n_vec++; if (spike_count !== 32'd2 || fifo_level !== LW'(2)) begin
      n_err++; $display("FAIL enable_rearm: got count=%0d level=%0d exp 2/2", spike_count, fifo_level);
    end
  endtask

  task automatic test_random();
    int tmp;
    do_reset();
    thr_hi = 100;
    for (int p = 0; p < 4; p++) begin
      thr_lo = (p % 2 == 0) ? 25'sd20 : -25'sd50;
      refract_cycles = RFR_WIDTH'($urandom_range(0, 6));
      for (int i = 0; i < 100; i++) begin
        cke          = ($urandom_range(0, 3) != 0);
        enable       = ($urandom_range(0, 19) != 0);
        tmp          = int'($urandom_range(0, 500)) - 200;
        v_out        = tmp[V_WIDTH-1:0];
        evt_ready    = (p < 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
        clr_overflow = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 9) == 0) emu_time = emu_time + 64'($urandom_range(1, 1000));
        tick();
        n_vec++; if (evt_valid !== (exp_q.size() != 0)) begin
          n_err++; $display("FAIL rnd_valid: got %b exp %b", evt_valid, exp_q.size() != 0);
        end
        n_vec++; if (fifo_level !== LW'(exp_q.size())) begin
          n_err++; $display("FAIL rnd_level: got %0d exp %0d", fifo_level, exp_q.size());
        end
        n_vec++; if (evt_time !== m_head) begin
          n_err++; $display("FAIL rnd_time: got %0d exp %0d", evt_time, m_head);
        end
        n_vec++; if (spike_count !== m_count) begin
          n_err++; $display("FAIL rnd_count: got %0d exp %0d", spike_count, m_count);
        end
        n_vec++; if (overflow !== m_ovf) begin
          n_err++; $display("FAIL rnd_ovf: got %b exp %b", overflow, m_ovf);
        end
      end
    end
    clr_overflow = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    emu_rst = 1'b0; cke = 1'b1; enable = 1'b1; v_out = '0;
    thr_hi = 100; thr_lo = 20; refract_cycles = 4; emu_time = '0;
    evt_ready = 1'b0; clr_overflow = 1'b0;
    model_clear();
    test_reset();
    test_single_spike();
    test_hysteresis();
    test_overflow();
    test_full_push_pop();
    test_cke_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
